// File: rtl/word_serializer.sv
`default_nettype none
// ============================================================================
// word_serializer: valid/ready parallel-to-serial unloader; each bit is held
// for PERIOD clocks and announced by a one-cycle sout_en strobe.
// Revision: 1.0
// ============================================================================
module word_serializer #(
    parameter int W         = 8,
    parameter int PERIOD    = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         sout,
    output logic         sout_en,
    output logic         frame,
    output logic         done
);

    localparam int BCNT_W = (W > 1) ? $clog2(W) : 1;
    localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(W - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        sr_q, sr_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic                sout_q, sout_d;
    logic                sout_en_q, sout_en_d;
    logic                frame_q, frame_d;

    logic                w_last_cycle;
    logic                w_accept;
    logic [W-1:0]        w_sr_shifted;
    logic                w_next_bit;
    logic                w_first_bit;

    assign w_last_cycle = (state_q == SHIFT) && (bcnt_q == BCNT_LAST) && (pcnt_q == PCNT_LAST);
    assign din_ready    = (state_q == IDLE) || w_last_cycle;
    assign done         = w_last_cycle;
    assign w_accept     = din_valid && din_ready;

    // The bit on sout always sits at the output end of sr, so shifting once
    // exposes the next bit at that same end.
    assign w_sr_shifted = MSB_FIRST ? {sr_q[W-2:0], 1'b0} : {1'b0, sr_q[W-1:1]};
    assign w_next_bit   = MSB_FIRST ? w_sr_shifted[W-1] : w_sr_shifted[0];
    assign w_first_bit  = MSB_FIRST ? din[W-1] : din[0];

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bcnt_d    = bcnt_q;
        pcnt_d    = pcnt_q;
        sout_d    = sout_q;
        sout_en_d = 1'b0;
        frame_d   = frame_q;

        if (w_accept) begin
            state_d   = SHIFT;
            sr_d      = din;
            bcnt_d    = '0;
            pcnt_d    = '0;
            sout_d    = w_first_bit;
            sout_en_d = 1'b1;
            frame_d   = 1'b1;
        end else if (state_q == SHIFT) begin
            if (pcnt_q != PCNT_LAST) begin
                pcnt_d = pcnt_q + PCNT_W'(1);
            end else if (bcnt_q != BCNT_LAST) begin
                pcnt_d    = '0;
                bcnt_d    = bcnt_q + BCNT_W'(1);
                sr_d      = w_sr_shifted;
                sout_d    = w_next_bit;
                sout_en_d = 1'b1;
            end else begin
                state_d = IDLE;
                sout_d  = 1'b0;
                frame_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bcnt_q    <= '0;
            pcnt_q    <= '0;
            sout_q    <= 1'b0;
            sout_en_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bcnt_q    <= bcnt_d;
            pcnt_q    <= pcnt_d;
            sout_q    <= sout_d;
            sout_en_q <= sout_en_d;
            frame_q   <= frame_d;
        end
    end

    assign sout    = sout_q;
    assign sout_en = sout_en_q;
    assign frame   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_word_serializer.sv
`default_nettype none
// tb_word_serializer: table-driven check of word_serializer (W=8, PERIOD=3,
// MSB first) plus hand sequences for mid-frame reset and a PERIOD=1 LSB-first instance.
module tb_word_serializer;

    logic       clk;
    logic       rst_b;
    logic [7:0] din0, din1;
    logic       vld0, vld1;
    logic       rdy0, rdy1, sout0, sout1, en0, en1, frame0, frame1, done0, done1;
    logic [4:0] got0, got1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic [4:0] exp;    // {sout, sout_en, frame, done, din_ready}
        string      name;
    } vec_t;

    vec_t vq[$];

    word_serializer #(.W(8), .PERIOD(3), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_b(rst_b), .din(din0), .din_valid(vld0), .din_ready(rdy0),
        .sout(sout0), .sout_en(en0), .frame(frame0), .done(done0)
    );

    word_serializer #(.W(8), .PERIOD(1), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_b(rst_b), .din(din1), .din_valid(vld1), .din_ready(rdy1),
        .sout(sout1), .sout_en(en1), .frame(frame1), .done(done1)
    );

    assign got0 = {sout0, en0, frame0, done0, rdy0};
    assign got1 = {sout1, en1, frame1, done1, rdy1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int step, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: {sout,sout_en,frame,done,din_ready} got %b required %b",
                     nm, step, got, exp);
        end
    endtask

    // One vector per cycle of an 8-bit, PERIOD=3, MSB-first frame; cycle c is
    // the c-th cycle after the accepting edge. Extra din_valid pulses carry 0xFF.
    task automatic push_frame(input logic [7:0] w, input bit hold, input int noise_c,
                              input int ncyc, input string nm);
        for (int c = 1; c <= ncyc; c++) begin
            vec_t v;
            int   i;
            i      = (c - 1) / 3;
            v.vld  = (c == 1) || hold || (c == noise_c);
            v.din  = (c == 1) ? w : 8'hFF;
            v.exp  = {w[7-i], ((c - 1) % 3) == 0, 1'b1, c == 24, c == 24};
            v.name = nm;
            vq.push_back(v);
        end
    endtask

    task automatic push_idle(input int n, input string nm);
        for (int c = 0; c < n; c++) begin
            vec_t v;
            v.vld  = 1'b0;
            v.din  = 8'h00;
            v.exp  = 5'b00001;
            v.name = nm;
            vq.push_back(v);
        end
    endtask

    task automatic apply_all();
        foreach (vq[k]) begin
            din0 = vq[k].din;
            vld0 = vq[k].vld;
            @(posedge clk);
            #1;
            check(vq[k].name, k, got0, vq[k].exp);
        end
        vld0 = 1'b0;
        vq.delete();
    endtask

    initial begin
        rst_b = 1'b0;
        vld0  = 1'b0;
        din0  = 8'h00;
        vld1  = 1'b0;
        din1  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_u0", 0, got0, 5'b00001);
        check("reset_u1", 0, got1, 5'b00001);
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", 0, got0, 5'b00001);

        push_frame(8'hA5, 1'b0, 0, 24, "single_a5");
        push_idle(2, "after_a5");
        apply_all();

        push_frame(8'hA5, 1'b1, 0, 24, "b2b_a5");
        push_frame(8'h3C, 1'b1, 0, 24, "b2b_3c");
        push_idle(1, "after_b2b");
        apply_all();

        push_frame(8'hA5, 1'b0, 11, 24, "noise_bit3");
        push_idle(1, "after_noise");
        apply_all();

        // Asynchronous reset in the first cycle of bit 5, well away from any edge.
        push_frame(8'hA5, 1'b0, 0, 16, "pre_reset");
        apply_all();
        #2 rst_b = 1'b0;
        #1 check("mid_frame_reset_async", 0, got0, 5'b00001);
        @(posedge clk);
        #1;
        check("mid_frame_reset_held", 0, got0, 5'b00001);
        rst_b = 1'b1;
        push_frame(8'h5A, 1'b0, 0, 24, "post_reset_5a");
        push_idle(1, "after_5a");
        apply_all();

        din1 = 8'h01;
        vld1 = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            vld1 = 1'b0;
            din1 = 8'hFF;
            check("period1_lsb", c, got1, {c == 1, 1'b1, 1'b1, c == 8, c == 8});
        end
        @(posedge clk);
        #1;
        check("period1_idle", 9, got1, 5'b00001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
